// File: rtl/spi_pkg.sv
// Shared definitions for the draw-command SPI link.
// The transmitter and the receiving packet decoder both take their field
// layout from pack_cmd, so the frame format lives only here.
package spi_pkg;

  localparam int unsigned FRAME_BITS = 24;
  localparam logic        HDR_MARK   = 1'b1;

  typedef struct packed {
    logic       brush;
    logic [2:0] color;
    logic [7:0] x;
    logic [7:0] y;
  } draw_cmd_t;

  // Transmitter states, kept as plain constants for older consumers.
  typedef logic [1:0] tx_state_t;
  localparam tx_state_t IDLE  = 2'd0;
  localparam tx_state_t SHIFT = 2'd1;
  localparam tx_state_t HOLD  = 2'd2;
  localparam tx_state_t GAP   = 2'd3;

  // Frame layout: {mark, 3'b000, brush, color} , x , y -- sent MSB first.
  function automatic logic [FRAME_BITS-1:0] pack_cmd(input draw_cmd_t cmd);
    return {HDR_MARK, 3'b000, cmd.brush, cmd.color, cmd.x, cmd.y};
  endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// SPI clock generator: divides clk into sck half-periods of CLK_DIV cycles.
// Ports:
//   clk, reset : system clock, synchronous active-high reset
//   en         : count half-periods; when low the counter and sck are cleared
//   park       : keep sck low at the end of the current half-period
//   sck        : SPI clock, idles low
//   rise_stb   : sck rises on the coming clk edge
//   fall_stb   : sck falls on the coming clk edge
module spi_sck_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic park,
  output logic sck,
  output logic rise_stb,
  output logic fall_stb
);

  localparam int unsigned HP_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [HP_W-1:0] hp_cnt;
  logic            term;

  // Last cycle of the current half-period.
  assign term     = en && (hp_cnt == HP_W'(CLK_DIV - 1));
  assign rise_stb = term && !sck;
  assign fall_stb = term && sck;

  always_ff @(posedge clk) begin
    if (reset || !en) begin
      hp_cnt <= '0;
      sck    <= 1'b0;
    end else if (term) begin
      hp_cnt <= '0;
      sck    <= park ? 1'b0 : ~sck;
    end else begin
      hp_cnt <= hp_cnt + HP_W'(1);
    end
  end

endmodule

// File: rtl/spi_cmd_tx.sv
// SPI mode-0 master transmitter for draw commands.
// One command per valid/ready handshake is packed into a 24-bit frame and
// shifted MSB first on sdi, changing only while sck is low.
// Ports:
//   clk, reset           : system clock, synchronous active-high reset
//   cmd_valid/cmd_ready  : command handshake (ready only in IDLE, not in reset)
//   cmd_brush/color/x/y  : command fields, sampled on the accept edge only
//   sck, sdi, cs_n       : SPI clock (idles low), serial data, chip select
//   busy                 : frame in progress
//   frame_done           : one-cycle pulse on the first cycle after cs_n rises
module spi_cmd_tx
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned CS_GAP  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_brush,
  input  logic [2:0] cmd_color,
  input  logic [7:0] cmd_x,
  input  logic [7:0] cmd_y,
  output logic       sck,
  output logic       sdi,
  output logic       cs_n,
  output logic       busy,
  output logic       frame_done
);

  localparam int unsigned GAP_W = (CS_GAP > 0) ? $clog2(CS_GAP + 1) : 1;

  tx_state_t             state, state_nxt;
  logic [4:0]            bit_cnt, bit_cnt_nxt;
  logic [GAP_W-1:0]      gap_cnt, gap_cnt_nxt;
  logic [FRAME_BITS-1:0] shreg, shreg_nxt;
  logic                  done_nxt;
  logic                  rise_stb, fall_stb;
  draw_cmd_t             cmd_in;

  assign cmd_in    = '{brush: cmd_brush, color: cmd_color, x: cmd_x, y: cmd_y};
  assign cmd_ready = (state == IDLE) && !reset;
  // The shift register MSB is the line; clearing it drives sdi low.
  assign sdi       = shreg[FRAME_BITS-1];

  // HOLD reuses the half-period counter for its low-only stretch.
  spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
    .clk      (clk),
    .reset    (reset),
    .en       ((state == SHIFT) || (state == HOLD)),
    .park     (state == HOLD),
    .sck      (sck),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb)
  );

  // Next-state and datapath updates.
  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    gap_cnt_nxt = gap_cnt;
    shreg_nxt   = shreg;
    done_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          shreg_nxt   = pack_cmd(cmd_in);
          bit_cnt_nxt = 5'(FRAME_BITS - 1);
          state_nxt   = SHIFT;
        end
      end
      SHIFT: begin
        // Falling sck closes a bit; the last one leaves sdi in place for HOLD.
        if (fall_stb) begin
          if (bit_cnt == 5'd0) begin
            state_nxt = HOLD;
          end else begin
            shreg_nxt   = {shreg[FRAME_BITS-2:0], 1'b0};
            bit_cnt_nxt = bit_cnt - 5'd1;
          end
        end
      end
      HOLD: begin
        if (rise_stb) begin
          shreg_nxt = '0;
          done_nxt  = 1'b1;
          // The IDLE cycle in which the next command is taken is the last
          // cs_n-high cycle, so GAP itself lasts one cycle less than CS_GAP.
          if (CS_GAP >= 2) begin
            state_nxt   = GAP;
            gap_cnt_nxt = GAP_W'(CS_GAP - 2);
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      GAP: begin
        if (gap_cnt == '0) state_nxt = IDLE;
        else               gap_cnt_nxt = gap_cnt - GAP_W'(1);
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      shreg      <= '0;
      cs_n       <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      bit_cnt    <= bit_cnt_nxt;
      gap_cnt    <= gap_cnt_nxt;
      shreg      <= shreg_nxt;
      cs_n       <= !((state_nxt == SHIFT) || (state_nxt == HOLD));
      busy       <= (state_nxt != IDLE);
      frame_done <= done_nxt;
    end
  end

endmodule
